arbiter: RTL and testbench

ARBITER -- requirements
Module: arbiter

---
 rtl/arbiter_pkg.sv | 25 ++
 rtl/arbiter_prio_enc.sv | 34 +++
 rtl/arbiter.sv | 77 +++++++
 tb/tb_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter.
package arbiter_pkg;

   // Default number of requesters and the matching pointer width.
   localparam int NUM_REQ_DEF = 4;
   localparam int PTR_W       = $clog2(NUM_REQ_DEF);

   // Widest supported request vector and the index width that covers it.
   localparam int MAX_REQ   = 16;
   localparam int MAX_PTR_W = 4;

   // Convert a one-hot (or all-zero) vector into the index of its set bit.
   // An all-zero input yields index 0; callers qualify it with a valid flag.
   function automatic logic [MAX_PTR_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_PTR_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/arbiter_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module arbiter_prio_enc
   import arbiter_pkg::*;
#(
   parameter int W   = NUM_REQ_DEF,
   parameter int P_W = $clog2(W)
) (
   input  logic [W-1:0]   i_req,
   output logic           o_valid,
   output logic [P_W-1:0] o_idx,
   output logic [W-1:0]   o_onehot
);

   logic [MAX_PTR_W-1:0] w_idx_full;
   logic                 w_unused_idx;

   // Walk from the top index down so the lowest set bit is the last one written.
   always_comb begin
      o_onehot = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_onehot    = '0;
            o_onehot[i] = 1'b1;
         end
      end
   end

   assign o_valid      = |i_req;
   assign w_idx_full   = onehot_to_idx(MAX_REQ'(o_onehot));
   assign o_idx        = w_idx_full[P_W-1:0];
   // Upper index bits are always zero for narrower vectors.
   assign w_unused_idx = &{1'b0, w_idx_full};

endmodule

// File: rtl/arbiter.sv
// Work-conserving round-robin arbiter: one registered grant decision per
// rising edge of ack, searching from the index after the last winner.
module arbiter
   import arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic               ack,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant
);

   localparam int L_PTR_W = $clog2(NUM_REQ);

   logic [L_PTR_W-1:0] r_last;
   logic [NUM_REQ-1:0] r_grant;

   logic [NUM_REQ-1:0] w_mask;
   logic [NUM_REQ-1:0] w_req_masked;
   logic               w_m_valid;
   logic [L_PTR_W-1:0] w_m_idx;
   logic [NUM_REQ-1:0] w_m_onehot;
   logic               w_u_valid;
   logic [L_PTR_W-1:0] w_u_idx;
   logic [NUM_REQ-1:0] w_u_onehot;
   logic [NUM_REQ-1:0] w_next_grant;
   logic [L_PTR_W-1:0] w_next_last;

   // Keep only indices strictly above last. When last is the top index the
   // shift overflows to zero and the mask clears, forcing the unmasked path.
   assign w_mask       = ~((NUM_REQ'(2) << r_last) - NUM_REQ'(1));
   assign w_req_masked = req & w_mask;

   arbiter_prio_enc #(.W(NUM_REQ), .P_W(L_PTR_W)) u_enc_masked (
      .i_req    (w_req_masked),
      .o_valid  (w_m_valid),
      .o_idx    (w_m_idx),
      .o_onehot (w_m_onehot)
   );

   arbiter_prio_enc #(.W(NUM_REQ), .P_W(L_PTR_W)) u_enc_unmasked (
      .i_req    (req),
      .o_valid  (w_u_valid),
      .o_idx    (w_u_idx),
      .o_onehot (w_u_onehot)
   );

   // Prefer the masked winner (wrap-free part of the search); fall back to the
   // unmasked winner, which covers the wrap and the sole-holder case.
   always_comb begin
      w_next_grant = '0;
      w_next_last  = r_last;
      if (w_m_valid) begin
         w_next_grant = w_m_onehot;
         w_next_last  = w_m_idx;
      end else if (w_u_valid) begin
         w_next_grant = w_u_onehot;
         w_next_last  = w_u_idx;
      end
   end

   // Grant and pointer registers; reset points last at the top index so the
   // first search begins at index 0.
   always_ff @(posedge ack or posedge rst) begin
      if (rst) begin
         r_grant <= '0;
         r_last  <= L_PTR_W'(NUM_REQ - 1);
      end else begin
         r_grant <= w_next_grant;
         r_last  <= w_next_last;
      end
   end

   assign grant = r_grant;

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for the 4-requester round-robin arbiter.
module tb_arbiter;

   logic       ack;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;

   int total;
   int bad;
   int model_last;
   logic [3:0] prev_req;
   logic [3:0] exp_g;

   arbiter #(.NUM_REQ(4)) dut (
      .ack   (ack),
      .rst   (rst),
      .req   (req),
      .grant (grant)
   );

   initial ack = 1'b0;
   always #5 ack = ~ack;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Drive a request pattern between edges, then sample just after the edge.
   task automatic step(input logic [3:0] r, input logic [3:0] exp, input string tag);
      @(negedge ack);
      req = r;
      @(posedge ack);
      #1;
      check(tag, grant, exp);
   endtask

   task automatic do_reset();
      @(negedge ack);
      rst = 1'b1;
      req = 4'b0000;
      #2;
      check("reset_grant", grant, 4'b0000);
      @(negedge ack);
      rst = 1'b0;
   endtask

   // Reference round robin: scan last+1 .. last+4 modulo 4.
   function automatic logic [3:0] rr_model(input logic [3:0] r, inout int last);
      logic [3:0] g;
      int idx;
      g = 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         idx = (last + k) % 4;
         if (g == 4'b0000 && r[idx]) begin
            g[idx] = 1'b1;
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (g[k]) last = k;
      end
      return g;
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req   = 4'b0000;
      #2;
      check("por_grant", grant, 4'b0000);

      // Single requester keeps being re-granted.
      do_reset();
      step(4'b0001, 4'b0001, "single_e1");
      step(4'b0001, 4'b0001, "single_e2");
      step(4'b0001, 4'b0001, "single_e3");

      // All requesting: full rotation and wrap.
      do_reset();
      step(4'b1111, 4'b0001, "all_e1");
      step(4'b1111, 4'b0010, "all_e2");
      step(4'b1111, 4'b0100, "all_e3");
      step(4'b1111, 4'b1000, "all_e4");
      step(4'b1111, 4'b0001, "all_e5");

      // Two requesters alternate.
      do_reset();
      step(4'b0011, 4'b0001, "pair_e1");
      step(4'b0011, 4'b0010, "pair_e2");
      step(4'b0011, 4'b0001, "pair_e3");
      step(4'b0011, 4'b0010, "pair_e4");

      // last=1, then 1010 alternates; idle keeps last; wrap to 0 from last=3.
      do_reset();
      step(4'b0010, 4'b0010, "set_last1");
      step(4'b1010, 4'b1000, "alt_e1");
      step(4'b1010, 4'b0010, "alt_e2");
      step(4'b1010, 4'b1000, "alt_e3");
      step(4'b0000, 4'b0000, "idle");
      step(4'b1111, 4'b0001, "after_idle");

      // Holder with another requester yields; withdrawn request loses grant.
      step(4'b0101, 4'b0100, "yield");
      step(4'b0001, 4'b0001, "withdraw");

      // Req changes between edges do not reach grant.
      @(negedge ack);
      req = 4'b1000;
      #2;
      check("no_comb_path", grant, 4'b0001);
      @(posedge ack);
      #1;
      check("latched_next", grant, 4'b1000);

      // Asynchronous reset mid-operation.
      @(negedge ack);
      rst = 1'b1;
      #1;
      check("async_rst", grant, 4'b0000);
      @(posedge ack);
      #1;
      check("rst_held", grant, 4'b0000);
      @(negedge ack);
      rst = 1'b0;
      step(4'b1111, 4'b0001, "post_rst");

      // Sweep odd patterns, four edges each, against the reference model.
      do_reset();
      model_last = 3;
      prev_req   = 4'b0000;
      for (int v = 0; v < 16; v++) begin
         for (int e = 0; e < 4; e++) begin
            prev_req = 4'((2 * v + 1) % 16);
            exp_g    = rr_model(prev_req, model_last);
            step(prev_req, exp_g, "sweep_order");
            total++;
            assert ($countones(grant) <= 1 && (grant & ~prev_req) == 4'b0000) else begin
               bad++;
               $error("FAIL sweep_shape observed=%b expected=subset_of_%b", grant, prev_req);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
